fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch register. It is a DEPTH-entry first-word-fall-through instruction queue that sits between program memory and the decoder. Each entry is split into an opcode field (instr) and an operand field (operando). A valid/ready handshake on both sides lets memory prefetch ahead while the decoder stalls. A synchronous flush discards all prefetched words on a jump.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_mem.sv | 36 +++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and width helpers for the fetch queue slice.
package fetch_pkg;

  localparam int INSTR_W_DEF = 4;
  localparam int OPER_W_DEF  = 4;
  localparam int DEPTH_DEF   = 4;

  // Pointer width; a depth of 2 still needs one address bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count must hold the value DEPTH itself, hence depth+1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x W register array: one enabled write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int W     = INSTR_W_DEF + OPER_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] entry [DEPTH];

  // One enabled flop row per entry, cleared by the async reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic sel;
    assign sel = we && (waddr == AW'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry[i] <= '0;
      end else if (sel) begin
        entry[i] <= wdata;
      end
    end
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between program memory and decoder.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPER_W  = OPER_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        R,
  input  logic                        E,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [INSTR_W+OPER_W-1:0]   in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTR_W-1:0]          instr,
  output logic [OPER_W-1:0]           operando,
  output logic [cnt_w(DEPTH)-1:0]     count
);

  localparam int W  = INSTR_W + OPER_W;
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  head;
  logic          push;
  logic          pop;

  assign in_ready  = E && (count != CW'(DEPTH));
  assign out_valid = E && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A flushed cycle must not write, so the dropped word never lands in storage.
  fetch_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (R),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign instr    = head[W-1:OPER_W];
  assign operando = head[OPER_W-1:0];

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (E) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       E = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] instr;
  logic [3:0] operando;
  logic [2:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(.INSTR_W(4), .OPER_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .R         (R),
    .E         (E),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .operando  (operando),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int req);
    n_chk++;
    if (obs == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, req);
  endtask

  // Advance through one rising edge; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] w);
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".instr"}, int'(instr), int'(w[7:4]));
    chk({tag, ".oper"},  int'(operando), int'(w[3:0]));
  endtask

  logic [7:0] sb[$];
  logic [7:0] fill_words [4] = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};

  initial begin
    // 1: reset then idle
    step();
    step();
    R = 1'b0;
    E = 1'b1;
    #1;
    chk("rst.count", int'(count), 0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.instr", int'(instr), 0);
    chk("rst.oper", int'(operando), 0);
    @(negedge clk);

    // 2: fill to full, reject fifth push, drain in order
    push_word(8'h1A);
    chk_head("lat1", 8'h1A);
    chk("lat1.count", int'(count), 1);
    push_word(8'h2B);
    push_word(8'h3C);
    push_word(8'h4D);
    chk("full.count", int'(count), 4);
    chk("full.in_ready", int'(in_ready), 0);
    push_word(8'h5E);
    chk("full.reject", int'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("drain%0d", i), fill_words[i]);
      step();
    end
    chk("drained.valid", int'(out_valid), 0);
    chk("drained.count", int'(count), 0);
    step();
    chk("underflow.count", int'(count), 0);
    out_ready = 1'b0;

    // 3: simultaneous push/pop at count=2, crossing pointer wrap
    push_word(8'h1A);
    push_word(8'h2B);
    sb.push_back(8'h1A);
    sb.push_back(8'h2B);
    chk("pp.count0", int'(count), 2);
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'b1;
      in_data   = 8'h77 + 8'(k);
      out_ready = 1'b1;
      chk_head($sformatf("pp%0d", k), sb[0]);
      step();
      void'(sb.pop_front());
      sb.push_back(8'h77 + 8'(k));
      chk($sformatf("pp%0d.count", k), int'(count), 2);
    end
    in_valid = 1'b0;
    while (sb.size() > 0) begin
      chk_head("pp.tail", sb[0]);
      step();
      void'(sb.pop_front());
    end
    chk("pp.empty", int'(out_valid), 0);
    out_ready = 1'b0;

    // 4: flush beats concurrent push and pop
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    chk("fl.count3", int'(count), 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl.count", int'(count), 0);
    chk("fl.out_valid", int'(out_valid), 0);
    chk("fl.in_ready", int'(in_ready), 1);
    push_word(8'h42);
    chk_head("fl.after", 8'h42);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fl.pop.count", int'(count), 0);

    // 5: enable hold, flush ignored while frozen
    push_word(8'h5A);
    push_word(8'h6B);
    E         = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    #1;
    chk("hold.in_ready", int'(in_ready), 0);
    chk("hold.out_valid", int'(out_valid), 0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      step();
      chk($sformatf("hold%0d.count", c), int'(count), 2);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    E         = 1'b1;
    #1;
    chk_head("hold.resume", 8'h5A);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk_head("hold.second", 8'h6B);
    step();
    out_ready = 1'b0;
    chk("hold.drained", int'(count), 0);

    // 6: asynchronous reset mid-stream
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    chk("ar.count3", int'(count), 3);
    #2;
    R = 1'b1;
    #1;
    chk("ar.count", int'(count), 0);
    chk("ar.out_valid", int'(out_valid), 0);
    chk("ar.instr", int'(instr), 0);
    chk("ar.oper", int'(operando), 0);
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    push_word(8'hD7);
    chk_head("ar.first", 8'hD7);
    chk("ar.first.count", int'(count), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
